// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL TDC decode path.
//   avg_state_t  : averager FSM states
//   AVG_LOG_DEF  : default log2 of the averaging block length
//   maj3         : 3-input majority, used for bubble correction
package adpll_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } avg_state_t;

  localparam int AVG_LOG_DEF = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tdc_edge_find.sv
// Combinational priority search for the lowest transition in a thermometer word.
//   c     : bubble-corrected thermometer word
//   pol   : 1 = rising edge (c[i-1]=0, c[i]=1), 0 = falling edge (c[i-1]=1, c[i]=0)
//   found : an edge of the requested polarity exists
//   pos   : lowest index i>=1 of that edge, 0 when not found
module tdc_edge_find #(
  parameter int N_TAPS = 64,
  parameter int POS_W  = 6
) (
  input  logic [N_TAPS-1:0] c,
  input  logic              pol,
  output logic              found,
  output logic [POS_W-1:0]  pos
);

  // Scan downward so the last hit written is the lowest index.
  always_comb begin
    found = 1'b0;
    pos   = '0;
    for (int i = N_TAPS - 1; i >= 1; i--) begin
      if ((c[i] == pol) && (c[i-1] != pol)) begin
        found = 1'b1;
        pos   = POS_W'(i);
      end
    end
  end

endmodule

// File: rtl/tdc_therm_decoder.sv
// Pipelined TDC thermometer decoder: sample register, bubble correction,
// edge search, and a block averager of the half-period.
//   clk, rst        : reference clock, synchronous active-high reset
//   en, tdc_q       : sample strobe and raw thermometer word
//   avg_clr         : abandon the partial average
//   valid           : rise_pos / half_period / no_edge valid
//   rise_pos        : lowest rising-edge tap
//   half_period     : |fall - rise| in taps, 0 if an edge is missing
//   no_edge         : rising or falling edge missing
//   period_avg      : 2 * mean(half_period) over 2^AVG_LOG samples
//   period_avg_vld  : one-cycle pulse on each period_avg update
module tdc_therm_decoder
  import adpll_pkg::*;
#(
  parameter int N_TAPS  = 64,
  parameter int POS_W   = 6,
  parameter int AVG_LOG = AVG_LOG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_TAPS-1:0] tdc_q,
  input  logic              avg_clr,
  output logic              valid,
  output logic [POS_W-1:0]  rise_pos,
  output logic [POS_W-1:0]  half_period,
  output logic              no_edge,
  output logic [POS_W:0]    period_avg,
  output logic              period_avg_vld
);

  localparam int AVG_N = 1 << AVG_LOG;
  localparam int ACC_W = POS_W + AVG_LOG;
  localparam int CNT_W = AVG_LOG + 1;

  logic [N_TAPS-1:0] s0, c_d, c1;
  logic              v0, v1;
  logic              rise_found, fall_found;
  logic [POS_W-1:0]  rise_idx, fall_idx, hp_d;

  avg_state_t        state, state_next;
  logic [ACC_W-1:0]  acc, acc_next, sum, sum_shr;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [POS_W:0]    avg_next;
  logic              avg_vld_next;

  // Bubble correction; the end taps reuse themselves as the missing neighbour.
  for (genvar g = 0; g < N_TAPS; g++) begin : g_bub
    localparam int LO = (g == 0) ? 0 : g - 1;
    localparam int HI = (g == N_TAPS - 1) ? N_TAPS - 1 : g + 1;
    assign c_d[g] = maj3(s0[LO], s0[g], s0[HI]);
  end

  tdc_edge_find #(.N_TAPS(N_TAPS), .POS_W(POS_W)) u_rise (
    .c(c1), .pol(1'b1), .found(rise_found), .pos(rise_idx)
  );

  tdc_edge_find #(.N_TAPS(N_TAPS), .POS_W(POS_W)) u_fall (
    .c(c1), .pol(1'b0), .found(fall_found), .pos(fall_idx)
  );

  // Fall may sit below rise when the edge wraps around the delay line.
  always_comb begin
    hp_d = '0;
    if (rise_found && fall_found)
      hp_d = (fall_idx >= rise_idx) ? (fall_idx - rise_idx) : (rise_idx - fall_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0          <= '0;
      v0          <= 1'b0;
      c1          <= '0;
      v1          <= 1'b0;
      valid       <= 1'b0;
      rise_pos    <= '0;
      half_period <= '0;
      no_edge     <= 1'b0;
    end else begin
      v0 <= en;
      if (en) s0 <= tdc_q;
      c1    <= c_d;
      v1    <= v0;
      valid <= v1;
      // Data outputs hold while no sample is present.
      if (v1) begin
        rise_pos    <= rise_idx;
        half_period <= hp_d;
        no_edge     <= ~(rise_found & fall_found);
      end
    end
  end

  assign sum     = acc + ACC_W'(half_period);
  assign sum_shr = sum >> (AVG_LOG - 1);

  always_comb begin
    state_next   = state;
    acc_next     = acc;
    cnt_next     = cnt;
    avg_next     = period_avg;
    avg_vld_next = 1'b0;
    if (avg_clr) begin
      state_next = IDLE;
      acc_next   = '0;
      cnt_next   = '0;
    end else if (valid && !no_edge) begin
      case (state)
        IDLE: begin
          state_next = ACCUM;
          acc_next   = ACC_W'(half_period);
          cnt_next   = CNT_W'(1);
        end
        ACCUM: begin
          if (cnt == CNT_W'(AVG_N - 1)) begin
            avg_next     = sum_shr[POS_W:0];
            avg_vld_next = 1'b1;
            state_next   = IDLE;
            acc_next     = '0;
            cnt_next     = '0;
          end else begin
            acc_next = sum;
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      cnt            <= '0;
      period_avg     <= '0;
      period_avg_vld <= 1'b0;
    end else begin
      state          <= state_next;
      acc            <= acc_next;
      cnt            <= cnt_next;
      period_avg     <= avg_next;
      period_avg_vld <= avg_vld_next;
    end
  end

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Directed bench for tdc_therm_decoder (16 taps, 4-sample average).
module tb_tdc_therm_decoder;

  logic        clk = 1'b0;
  logic        rst, en, avg_clr;
  logic [15:0] tdc_q;
  logic        valid, no_edge, period_avg_vld;
  logic [3:0]  rise_pos, half_period;
  logic [4:0]  period_avg;

  int total = 0;
  int bad   = 0;

  tdc_therm_decoder #(.N_TAPS(16), .POS_W(4), .AVG_LOG(2)) dut (
    .clk(clk), .rst(rst), .en(en), .tdc_q(tdc_q), .avg_clr(avg_clr),
    .valid(valid), .rise_pos(rise_pos), .half_period(half_period),
    .no_edge(no_edge), .period_avg(period_avg), .period_avg_vld(period_avg_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample at the current negedge; leaves en low at the next one.
  task automatic send(input logic [15:0] q);
    en    = 1'b1;
    tdc_q = q;
    @(negedge clk);
    en    = 1'b0;
  endtask

  task automatic apply_one(input string tag, input logic [15:0] q,
                           input int exp_rise, input int exp_hp, input int exp_ne);
    send(q);
    repeat (2) @(negedge clk);
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_rise"}, rise_pos, exp_rise);
    chk({tag, "_hp"}, half_period, exp_hp);
    chk({tag, "_noedge"}, no_edge, exp_ne);
    @(negedge clk);
    chk({tag, "_gap"}, valid, 0);
  endtask

  task automatic run_count(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      if (period_avg_vld) pulses++;
      @(negedge clk);
    end
  endtask

  task automatic clear_avg();
    avg_clr = 1'b1;
    @(negedge clk);
    avg_clr = 1'b0;
  endtask

  logic [15:0] seq4 [4] = '{16'h0FC0, 16'h0FC0, 16'h1FC0, 16'h1FC0};
  logic [15:0] seq5 [5] = '{16'h0FC0, 16'hFFFF, 16'h0FC0, 16'h1FC0, 16'h1FC0};
  int p, nv;

  initial begin
    rst = 1'b1; en = 1'b0; avg_clr = 1'b0; tdc_q = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_rise", rise_pos, 0);
    chk("rst_avg", period_avg, 0);
    chk("rst_avg_vld", period_avg_vld, 0);
    rst = 1'b0;
    @(negedge clk);

    apply_one("basic", 16'h0FC0, 6, 6, 0);
    apply_one("bubble", 16'h0FA0, 6, 6, 0);
    apply_one("wrap", 16'hFC0F, 10, 6, 0);
    apply_one("ones", 16'hFFFF, 0, 0, 1);
    apply_one("zeros", 16'h0000, 0, 0, 1);
    apply_one("rise_only", 16'hFF00, 8, 0, 1);

    // Discard what the single-sample tests accumulated.
    clear_avg();
    repeat (2) @(negedge clk);

    // 6,6,7,7 back to back: pulse one cycle after the 4th valid (negedge k=7).
    for (int i = 0; i < 4; i++) send(seq4[i]);
    for (int k = 4; k < 10; k++) begin
      chk("avg4_pulse", period_avg_vld, (k == 7));
      @(negedge clk);
    end
    chk("avg4_value", period_avg, 13);

    // Same with a no-edge sample interleaved; pulse moves one cycle later.
    for (int i = 0; i < 5; i++) send(seq5[i]);
    for (int k = 5; k < 11; k++) begin
      chk("avg5_pulse", period_avg_vld, (k == 8));
      @(negedge clk);
    end
    chk("avg5_value", period_avg, 13);

    // Partial block of 3, clear, then 4 samples of half-period 5.
    for (int i = 0; i < 3; i++) send(16'h0FC0);
    repeat (4) @(negedge clk);
    clear_avg();
    for (int i = 0; i < 4; i++) send(16'h07C0);
    run_count(8, p);
    chk("clr_pulses", p, 1);
    chk("clr_value", period_avg, 10);

    // avg_clr lands on the completing sample: no pulse, value held.
    for (int i = 0; i < 4; i++) send(16'h0FC0);
    repeat (2) @(negedge clk);
    chk("coin_valid", valid, 1);
    avg_clr = 1'b1;
    @(negedge clk);
    avg_clr = 1'b0;
    run_count(6, p);
    chk("coin_pulses", p, 0);
    chk("coin_value", period_avg, 10);

    // Fresh block after the clear must start from an empty accumulator.
    for (int i = 0; i < 4; i++) send(16'h1FC0);
    run_count(8, p);
    chk("post_coin_pulses", p, 1);
    chk("post_coin_value", period_avg, 14);

    // Reset with two samples in flight.
    send(16'h0FC0);
    en = 1'b1; tdc_q = 16'h0FC0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid) nv++;
      @(negedge clk);
    end
    chk("rst_flight_valid", nv, 0);
    chk("rst_flight_rise", rise_pos, 0);
    chk("rst_flight_hp", half_period, 0);
    chk("rst_flight_avg", period_avg, 0);

    // Continuous en for 20 cycles.
    for (int k = 0; k < 26; k++) begin
      chk("cont_valid", valid, (k >= 3 && k < 23));
      en    = (k < 20);
      tdc_q = 16'h0FC0;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
